// File: rtl/fx_bm_radius.sv
// fx_bm_radius: Box-Muller radius stage, radius = sqrt(-2 * ln u).
// Bit-serial non-restoring square root, one result bit per cycle.
// The parameter defaults match the platform fixed-point configuration (Q16.16 in 32 bits).
module fx_bm_radius #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned QINT  = 16,
    parameter int unsigned QFRAC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] ln_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] radius,
    output logic             sat_out
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned RW = WIDTH + 2;
    localparam int unsigned CW = $clog2(WIDTH);

    // Reject inconsistent fixed-point configurations at elaboration
    if ((WIDTH != QINT + QFRAC) || (QFRAC > WIDTH - 1) || (WIDTH < 4)) begin : g_bad_cfg
        $error("fx_bm_radius: inconsistent WIDTH/QINT/QFRAC");
    end

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    state_t            state;
    logic [RW-1:0]     rem;
    logic [WIDTH-1:0]  root;
    logic [DW-1:0]     rad;
    logic [CW-1:0]     cnt;
    logic              sat_q;

    logic              accept;
    logic [WIDTH-1:0]  neg;
    logic [WIDTH-1:0]  m_op;
    logic              sat_op;
    logic [RW-1:0]     r_sh;
    logic [RW-1:0]     q_t;
    logic [RW-1:0]     r_nxt;
    logic [RW-1:0]     r_fix;
    logic [WIDTH-1:0]  root_nxt;

    // Only combinational input-to-output path: DONE hands off and reloads in one edge
    assign ready_out = (state == IDLE) || ((state == DONE) && ready_in);
    assign accept    = valid_in && ready_out;

    // Operand m = -2*ln: zero for non-negative logs, saturated when it does not fit
    always_comb begin
        neg    = -ln_in;
        m_op   = '0;
        sat_op = 1'b0;
        if (!ln_in[WIDTH-1]) begin
            m_op = '0;
        end else if (ln_in[WIDTH-2] && (ln_in[WIDTH-3:0] != '0)) begin
            m_op = neg << 1;
        end else begin
            m_op   = {1'b0, {(WIDTH-1){1'b1}}};
            sat_op = 1'b1;
        end
    end

    // One non-restoring step: add (4Q+3) on a negative remainder, subtract (4Q+1) otherwise
    always_comb begin
        r_sh     = RW'({rem, rad[DW-1 -: 2]});
        q_t      = {root, rem[RW-1], 1'b1};
        r_nxt    = rem[RW-1] ? (r_sh + q_t) : (r_sh - q_t);
        root_nxt = {root[WIDTH-2:0], ~r_nxt[RW-1]};
        r_fix    = r_nxt[RW-1] ? (r_nxt + RW'({root_nxt, 1'b1})) : r_nxt;
    end

    // Control FSM, iteration datapath and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            root      <= '0;
            rad       <= '0;
            cnt       <= '0;
            sat_q     <= 1'b0;
            valid_out <= 1'b0;
            radius    <= '0;
            sat_out   <= 1'b0;
        end else begin
            case (state)
                ITER: begin
                    rem  <= r_nxt;
                    root <= root_nxt;
                    rad  <= rad << 2;
                    cnt  <= cnt - CW'(1);
                    if (cnt == '0) begin
                        rem       <= r_fix;
                        radius    <= root_nxt;
                        sat_out   <= sat_q;
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Accept happens only in IDLE or in DONE during the hand-off
            if (accept) begin
                rem   <= '0;
                root  <= '0;
                rad   <= DW'(m_op) << QFRAC;
                sat_q <= sat_op;
                cnt   <= CW'(WIDTH - 1);
                state <= ITER;
            end
        end
    end

endmodule

// File: tb/tb_fx_bm_radius.sv
// Scoreboard bench for fx_bm_radius: the driver queues expected results on acceptance,
// an independent monitor pops and compares on every output hand-off.
module tb_fx_bm_radius;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] ln_in;
    logic             valid_out;
    logic             ready_in;
    logic [WIDTH-1:0] radius;
    logic             sat_out;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;
    int rdy_mode = 0;

    logic [WIDTH-1:0] exp_r[$];
    logic             exp_s[$];

    logic             hold_v = 1'b0;
    logic [WIDTH-1:0] hold_r;
    logic             hold_s;

    fx_bm_radius #(.WIDTH(32), .QINT(16), .QFRAC(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .ln_in     (ln_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .radius    (radius),
        .sat_out   (sat_out)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference: m = -2*ln as a real-valued integer, radius = floor(sqrt(m * 2^16))
    function automatic void model(input logic [31:0] ln, output logic [31:0] r, output logic s);
        longint v;
        longint m;
        longint big_r;
        longint lo;
        longint hi;
        longint mid;
        v = longint'($signed(ln));
        s = 1'b0;
        if (v >= 0) begin
            m = 0;
        end else if (-2 * v <= 64'sd2147483647) begin
            m = -2 * v;
        end else begin
            m = 64'sd2147483647;
            s = 1'b1;
        end
        big_r = m * 65536;
        lo = 0;
        hi = 64'sd1 << 24;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= big_r) lo = mid;
            else hi = mid - 1;
        end
        r = 32'(lo);
    endfunction

    // Downstream ready policy: 0 = always ready, 1 = random, 2 = driven by the test
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) ready_in = 1'b1;
        else if (rdy_mode == 1) ready_in = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare every hand-off against the scoreboard and watch held outputs
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 64'(valid_out), 64'd1);
                check("hold_radius", 64'(radius), 64'(hold_r));
                check("hold_sat", 64'(sat_out), 64'(hold_s));
            end
            if (valid_out && ready_in) begin
                if (exp_r.size() == 0) begin
                    check("unexpected_out", 64'(valid_out), 64'd0);
                end else begin
                    check("radius", 64'(radius), 64'(exp_r.pop_front()));
                    check("sat", 64'(sat_out), 64'(exp_s.pop_front()));
                end
                n_out++;
                hold_v = 1'b0;
            end else if (valid_out) begin
                hold_v = 1'b1;
                hold_r = radius;
                hold_s = sat_out;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // Present one operand, wait (bounded) for acceptance, queue its expected result.
    // Must be called just after a rising edge; returns one step after the accept edge.
    task automatic issue(input logic [31:0] ln, input logic [31:0] er, input logic es, output int waited);
        bit ok;
        ln_in    = ln;
        valid_in = 1'b1;
        waited   = 0;
        ok       = 1'b0;
        while (!ok && waited < 500) begin
            @(negedge clk);
            if (ready_out) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            check("accept_timeout", 64'(waited), 64'd0);
        end else begin
            exp_r.push_back(er);
            exp_s.push_back(es);
            n_in++;
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        ln_in    = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count rising edges from an accept until valid_out appears
    task automatic latency(output int lat);
        lat = 0;
        while (!valid_out && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [31:0] ln;
        logic [31:0] r;
        logic        s;
    } vec_t;

    initial begin
        vec_t        sweep[5];
        int          w;
        int          lat;
        int          seen;
        logic [31:0] er;
        logic        es;
        logic [31:0] ln;

        sweep[0] = '{32'hFFFE0000, 32'h00020000, 1'b0};
        sweep[1] = '{32'h00000000, 32'h00000000, 1'b0};
        sweep[2] = '{32'h0000B172, 32'h00000000, 1'b0};
        sweep[3] = '{32'h80000000, 32'h00B504F3, 1'b1};
        sweep[4] = '{32'hC0000000, 32'h00B504F3, 1'b1};

        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        ln_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_radius", 64'(radius), 64'd0);
        check("rst_sat_out", 64'(sat_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready_out", 64'(ready_out), 64'd1);

        // Basic value and exact latency
        issue(32'hFFFF8000, 32'h00010000, 1'b0, w);
        latency(lat);
        check("latency_basic", 64'(lat), 64'd32);
        idle(2);

        // Exact, clamped and saturated operands back-to-back
        foreach (sweep[i]) issue(sweep[i].ln, sweep[i].r, sweep[i].s, w);
        idle(40);

        // Backpressure in DONE, then hand-off with a new operand on the same edge
        rdy_mode = 2;
        ready_in = 1'b0;
        issue(32'hFFFE0000, 32'h00020000, 1'b0, w);
        latency(lat);
        check("latency_bp", 64'(lat), 64'd32);
        idle(10);
        ready_in = 1'b1;
        issue(32'hFFFF8000, 32'h00010000, 1'b0, w);
        check("b2b_accept_wait", 64'(w), 64'd0);
        latency(lat);
        check("latency_b2b", 64'(lat), 64'd32);
        rdy_mode = 0;
        idle(2);

        // Random ln in [-16.0, 0] with random gaps and random downstream readiness
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            idle(int'($urandom_range(0, 2)));
            ln = -32'($urandom_range(0, 32'h00100000));
            model(ln, er, es);
            issue(ln, er, es, w);
        end
        // Full-range operands exercise positive and saturating logs
        for (int i = 0; i < 100; i++) begin
            ln = $urandom;
            model(ln, er, es);
            issue(ln, er, es, w);
        end
        rdy_mode = 0;
        w = 0;
        while (exp_r.size() != 0 && w < 200) begin
            idle(1);
            w++;
        end
        check("drain_empty", 64'(exp_r.size()), 64'd0);
        check("count_in_out", 64'(n_out), 64'(n_in));

        // Reset mid-iteration discards the in-flight result
        issue(32'hFFFF8000, 32'h00010000, 1'b0, w);
        idle(15);
        rst_n = 1'b0;
        #1;
        check("abort_valid_out", 64'(valid_out), 64'd0);
        check("abort_radius", 64'(radius), 64'd0);
        check("abort_sat_out", 64'(sat_out), 64'd0);
        exp_r.delete();
        exp_s.delete();
        n_in--;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_out", 64'(ready_out), 64'd1);
        seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        check("abort_no_stale", 64'(seen), 64'd0);
        check("count_final", 64'(n_out), 64'(n_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fx_bm_radius.md
# fx_bm_radius

Box-Muller radius stage. It consumes the fixed-point natural log of a uniform sample from the `fxlnLUT` stage directly upstream and produces the Gaussian radius r = sqrt(-2·ln u). The square root is computed by an iterative, bit-serial, non-restoring method, one result bit per cycle. Its output feeds the cos/sin multiply stage that forms the normal variates for the QMC path generator.

## Interface
- `WIDTH`, default `fpga_cfg_pkg::FP_WIDTH`: total fixed-point width, two's complement.
- `QINT`, default `fpga_cfg_pkg::FP_QINT`: integer bits including sign.
- `QFRAC`, default `fpga_cfg_pkg::FP_QFRAC`: fraction bits. WIDTH = QINT + QFRAC and QFRAC ≤ WIDTH-1 are elaboration-time assertions.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `valid_in` in 1: `ln_in` is valid.
- `ready_out` out 1: the block can accept an input this cycle.
- `ln_in` in WIDTH: signed Q(QINT.QFRAC) value of ln u.
- `valid_out` out 1: `radius` is valid.
- `ready_in` in 1: downstream accepts `radius`.
- `radius` out WIDTH: unsigned-valued Q(QINT.QFRAC) result; the MSB is always 0.
- `sat_out` out 1: saturation occurred for this result. Qualified by `valid_out`.

## Operation
- FSM states: IDLE, ITER, DONE.
- `ready_out` = (state==IDLE) || (state==DONE && `ready_in`).
- **Accept.** An input is accepted on an edge where `valid_in && ready_out`. At that edge the block latches the operand m and moves to ITER with iteration counter = WIDTH-1.
- **Operand m:**
  - `ln_in` ≥ 0 (upstream clamps u up to 2, so small positive logs occur): m = 0, sat = 0.
  - -2·`ln_in` fits in signed WIDTH: m = -2·`ln_in`, computed exactly as a left shift of the negated value.
  - Otherwise, including `ln_in` = most-negative: m = 2^(WIDTH-1)-1, sat = 1.
- **Radicand.** R = m << QFRAC, held in a 2·WIDTH-bit unsigned register. radius = floor(sqrt(R)), which is the truncated Q-format sqrt of m.
- **ITER.** Each cycle resolves one result bit, MSB first (bit = counter). Working registers:
  - remainder: signed, WIDTH+2 bits.
  - partial root: WIDTH bits.
  - shifted radicand: 2·WIDTH bits.
- The counter decrements each cycle. After the bit-0 cycle, the block applies the final remainder correction (not needed by the root value), then moves to DONE.
- **DONE.** `valid_out` = 1. `radius` and `sat_out` are held stable while `ready_in` = 0.
  - `ready_in` = 1 with no new `valid_in`: go to IDLE.
  - `ready_in` = 1 with `valid_in`: the new operand is latched on the same edge and the state goes straight to ITER (back-to-back).
- **Held result.** `radius` is loaded only on the ITER→DONE edge and otherwise holds its value. After a hand-off it keeps the last value, but `valid_out` = 0 qualifies it.
- **Width rule.** floor(sqrt(R)) < 2^((WIDTH-1+QFRAC)/2) ≤ 2^(WIDTH-1), so the result never overflows. No result rounding is applied.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low): state = IDLE, `valid_out` = 0, `ready_out` = 1 as soon as reset releases, `radius` = 0, `sat_out` = 0, all working registers 0.
- Reset mid-ITER or mid-DONE aborts the calculation. The in-flight result is discarded; none is emitted after reset.
- Latency: an input accepted at edge t0 produces `valid_out` high in the cycle after edge t0+WIDTH, i.e. WIDTH cycles.
- Initiation interval: WIDTH+1 cycles with `ready_in` held high. There is no input buffering.
- `valid_out` stays high until it is accepted. It never drops without the handshake `valid_out && ready_in`.
- `valid_in` asserted while in ITER is not accepted (`ready_out` = 0). Upstream must hold its data.
- `ready_out` depends combinationally on `ready_in` only in DONE. This is the only comb path from input to output.

## Test plan
All scenarios use WIDTH=32, QINT=16, QFRAC=16.

- **Basic value.** `ln_in` = 0xFFFF8000 (-0.5) -> `radius` = 0x00010000, `sat_out` = 0, `valid_out` exactly 32 cycles after acceptance.
- **Sweep of exact and clamped values:**
  - `ln_in` = 0xFFFE0000 (-2.0) -> 0x00020000.
  - `ln_in` = 0x00000000 -> 0x00000000.
  - `ln_in` = 0x0000B172 (+0.693) -> 0x00000000, `sat_out` = 0.
- **Saturation.** `ln_in` = 0x80000000 -> `sat_out` = 1, `radius` = 0x00B504F3. `ln_in` = 0xC0000000 -> `sat_out` = 1, same radius.
- **Backpressure.** `ready_in` held low for 10 cycles in DONE -> `radius`, `sat_out` and `valid_out` stable throughout. When `ready_in` rises with `valid_in` high, the next input is accepted on that edge and the next result arrives 32 cycles later.
- **Random reference.** 1000 random `ln_in` in [-16.0, 0] checked against a floor(sqrt(m·2^16)) reference model -> bit-exact match. Random `valid_in`/`ready_in` toggling -> no lost or duplicated results.
- **Reset abort.** `rst_n` pulsed low at iteration 15 -> `valid_out` = 0 and `radius` = 0 immediately, and `ready_out` = 1 after release. No stale result is emitted.
